// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with prioritised redirects, stall hold,
// misaligned-target trapping and a small circular return-address stack.
module pc_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             exception,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call_push,
  input  logic             ret_pop,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misaligned,
  output logic             ras_underflow
);

  localparam int unsigned      PW         = $clog2(RAS_DEPTH);
  localparam int unsigned      CW         = PW + 1;
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
  localparam logic [CW-1:0]    CNT_FULL   = CW'(RAS_DEPTH);

  // RAS storage; entries carry no reset value, only pointer and count do
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, top_idx, wr_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en;
  logic             ras_nonempty;
  logic             active;
  logic [WIDTH-1:0] ras_top;

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] target;
  logic             redirect;
  logic             mis_d;
  logic             und_d;

  assign pc_plus_inc  = pc_out + INC_W;
  assign ras_nonempty = (cnt_q != '0);
  assign ras_empty    = (cnt_q == '0);
  assign ras_full     = (cnt_q == CNT_FULL);
  assign active       = !exception && !stall;
  assign top_idx      = ptr_q - PW'(1);
  assign ras_top      = ras_mem[top_idx];

  // RAS pointer/count update and write-port selection
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (active) begin
      if (call_push && ret_pop && ras_nonempty) begin
        // pop reads the old top, push replaces it in place: depth unchanged
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (call_push) begin
        // when full the write lands on the oldest slot and count saturates
        wr_en = 1'b1;
        ptr_d = ptr_q + PW'(1);
        if (cnt_q != CNT_FULL) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (ret_pop && ras_nonempty) begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Next-PC priority select with alignment trap on redirect targets
  always_comb begin
    pc_d     = pc_out;
    mis_d    = 1'b0;
    und_d    = 1'b0;
    redirect = 1'b0;
    target   = pc_plus_inc;
    if (exception) begin
      pc_d = EXC_VECTOR;
    end else if (!stall) begin
      if (branch_taken) begin
        redirect = 1'b1;
        target   = branch_target;
      end else if (jump) begin
        redirect = 1'b1;
        target   = jump_target;
      end else if (ret_pop && ras_nonempty) begin
        redirect = 1'b1;
        target   = ras_top;
      end
      und_d = ret_pop && !ras_nonempty;
      if (redirect && ((target & ALIGN_MASK) != '0)) begin
        pc_d  = EXC_VECTOR;
        mis_d = 1'b1;
      end else begin
        pc_d = target;
      end
    end
  end

  // PC, RAS bookkeeping and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out        <= RESET_VECTOR;
      ptr_q         <= '0;
      cnt_q         <= '0;
      misaligned    <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_out        <= pc_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      misaligned    <= mis_d;
      ras_underflow <= und_d;
    end
  end

  // RAS entry write (return address is always the current sequential PC)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_mem[wr_idx] <= pc_plus_inc;
    end
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the MIPS fetch stage. Successor to the plain clocked PC register.
- Adds asynchronous active-low reset to a reset vector, stall hold, and prioritised redirect for exception, branch, jump and return.
- Adds a small circular return-address stack (RAS) for call/return prediction, plus misaligned-target trapping.
- Sits between the next-PC logic/hazard unit and instruction memory; pc_out drives the instruction memory address.

Parameters:
- WIDTH, 32, PC and address width in bits (≥ 8).
- RESET_VECTOR, 32'h0000_0000, value loaded into pc_out on reset.
- EXC_VECTOR, 32'h8000_0180, target on exception or misaligned redirect.
- INC, 4, sequential increment in bytes (power of two).
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥ 2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC (hazard/memory wait).
- exception  in  1  redirect to EXC_VECTOR; overrides stall.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  redirect to jump_target.
- jump_target  in  WIDTH  jump destination.
- call_push  in  1  jal/jalr: push pc_out+INC onto RAS.
- ret_pop  in  1  jr $ra: pop RAS, redirect to popped value.
- pc_out  out  WIDTH  current PC (registered).
- pc_plus_inc  out  WIDTH  pc_out+INC (combinational, wraps modulo 2^WIDTH).
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- misaligned  out  1  registered one-cycle pulse on a trapped misaligned target.
- ras_underflow  out  1  registered one-cycle pulse on a pop from an empty RAS.

Behaviour:
- **Reset (async, rst_n=0):** pc_out=RESET_VECTOR, RAS count=0, RAS pointer=0, misaligned=0, ras_underflow=0. RAS entry contents are don't-care. The first edge with rst_n=1 applies normal next-PC rules.
- **Next-PC selection** (registered; one-cycle latency from inputs to pc_out). Priority, highest first:
  1. exception -> EXC_VECTOR. Applies even when stall=1.
  2. stall -> hold pc_out. All lower-priority inputs are ignored: no RAS change, no pulses.
  3. branch_taken -> branch_target.
  4. jump -> jump_target.
  5. ret_pop with RAS non-empty -> RAS top.
  6. Otherwise -> pc_out+INC, wrapping modulo 2^WIDTH.
- **Misalignment:**
  - If the selected target from rule 3, 4 or 5 has nonzero low log2(INC) bits, next pc_out=EXC_VECTOR and misaligned=1 for one cycle.
  - RAS side effects of that cycle still occur.
- **RAS push:**
  - On call_push when not stalled and no exception, write pc_out+INC at the pointer, then increment the pointer.
  - Count saturates at RAS_DEPTH. When full, the push overwrites the oldest entry (circular) and count stays RAS_DEPTH.
- **RAS pop:**
  - On ret_pop when not stalled and no exception: if count>0, decrement the pointer and count.
  - Pop on empty: pointer and count unchanged, PC goes sequential, ras_underflow=1 for one cycle.
- **Simultaneous push and pop** (RAS non-empty):
  - The pop target is the pre-update top.
  - The top entry is then replaced with pc_out+INC.
  - Count and pointer are unchanged.
- **Same-cycle RAS operation with a higher-priority redirect:**
  - RAS push/pop still execute when branch_taken or jump wins.
  - ret_pop's PC effect is suppressed in that case.
- **Exception cycle:** RAS is untouched; call_push and ret_pop are ignored.
- **Pointer arithmetic:** log2(RAS_DEPTH) bits, wraps naturally. Count is log2(RAS_DEPTH)+1 bits.
- **Reset mid-operation:** immediate (asynchronous) return to reset values, independent of clk.

Test Plan:
1. Assert rst_n=0 mid-cycle, release, then run 3 edges with no other inputs -> pc_out is 0 immediately on assertion, then 4, 8, 12. pc_plus_inc tracks pc_out+4.
2. At pc_out=0x100: stall=1 for 2 edges, then stall=1 with exception=1 -> pc_out holds 0x100, 0x100, then 0x8000_0180.
3. At pc_out=0x40: call_push, then 3 sequential cycles, then ret_pop -> RAS holds 0x44; pc_out goes to 0x44 after the pop and ras_empty=1.
4. Push 5 times with RAS_DEPTH=4 at PCs 0x10, 0x14, 0x18, 0x1C, 0x20 -> ras_full=1; successive pops return 0x24, 0x20, 0x1C, 0x18, then ras_underflow=1 and pc_out goes sequential.
5. branch_taken=1 and jump=1 together, branch_target=0x200, jump_target=0x300 -> pc_out=0x200. Then branch_target=0x202 -> pc_out=0x8000_0180 with a one-cycle misaligned pulse.
6. PC=0xFFFF_FFFC, no redirect -> pc_out wraps to 0x0000_0000. Separately, with RAS non-empty, call_push and ret_pop together -> pc_out=old top, top replaced with pc_out+4, count unchanged.
